// File: rtl/scan_pkg.sv
// Shared definitions for the scan test controller: FSM state encoding,
// MISR polynomial and the MISR step function.
package scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } scan_state_e;

  localparam logic [7:0] SCAN_MISR_POLY = 8'h1D;

  // One Galois-style step of x^8+x^4+x^3+x^2+1, folding in data.
  function automatic logic [7:0] misr_next(input logic [7:0] sig, input logic [7:0] data);
    logic [7:0] fb;
    fb = sig[7] ? SCAN_MISR_POLY : 8'h00;
    return {sig[6:0], 1'b0} ^ fb ^ data;
  endfunction

endpackage

// File: rtl/scan_misr.sv
// 8-bit multiple-input signature register; folds data_i on each en_i cycle
// and is cleared only by reset.
module scan_misr
  import scan_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] sig_o
);

  logic [7:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (en_i) sig_d = misr_next(sig_q, data_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sig_q <= 8'h00;
    else       sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/scan_ctrl8.sv
// Scan test controller: load pattern, capture, unload and compare for a scan chain.
// Optional response signature output wSig is built when SCAN_MISR_EN is defined.
module scan_ctrl8
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN   = 8,
  parameter int CAPT_CYCLES = 1
) (
  input  logic                 rclk,
  input  logic                 rreset,
  input  logic                 rStart,
  input  logic                 rNoCapt,
  input  logic [CHAIN_LEN-1:0] rPattern,
  input  logic [CHAIN_LEN-1:0] rExpect,
  input  logic                 rDfunc,
  input  logic                 rQ8,
  output logic                 wSE,
  output logic                 wSD,
  output logic                 wD,
  output logic [CHAIN_LEN-1:0] wResp,
  output logic                 wBusy,
  output logic                 wDone,
  output logic                 wMatch
`ifdef SCAN_MISR_EN
  ,
  output logic [7:0]           wSig
`endif
);

  localparam int CNT_W = $clog2(CHAIN_LEN) + 1;
  localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(CAPT_CYCLES - 1);

  // Handshake: rStart is accepted only in IDLE (one-cycle sample, no queueing);
  // wBusy covers the whole run and wDone pulses once with wResp/wMatch valid.
  scan_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] ld_q, ld_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] sh_q, sh_d;
  logic                 dfunc_q, dfunc_d;
  logic                 nocapt_q, nocapt_d;
  logic                 start_acc;

  logic                 se_q, se_d;
  logic                 sd_q, sd_d;
  logic                 d_q, d_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 match_q, match_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;

  always_ff @(posedge rclk) begin
    if (rreset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ld_q     <= '0;
      exp_q    <= '0;
      sh_q     <= '0;
      dfunc_q  <= 1'b0;
      nocapt_q <= 1'b0;
      se_q     <= 1'b0;
      sd_q     <= 1'b0;
      d_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      match_q  <= 1'b0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ld_q     <= ld_d;
      exp_q    <= exp_d;
      sh_q     <= sh_d;
      dfunc_q  <= dfunc_d;
      nocapt_q <= nocapt_d;
      se_q     <= se_d;
      sd_q     <= sd_d;
      d_q      <= d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      match_q  <= match_d;
      resp_q   <= resp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    ld_d      = ld_q;
    exp_d     = exp_q;
    dfunc_d   = dfunc_q;
    nocapt_d  = nocapt_q;
    start_acc = 1'b0;
    sh_d      = sh_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rStart) begin
          state_d   = ST_LOAD;
          ld_d      = rPattern;
          exp_d     = rExpect;
          dfunc_d   = rDfunc;
          nocapt_d  = rNoCapt;
          start_acc = 1'b1;
        end
      end
      ST_LOAD: begin
        // MSB of ld always holds the bit being driven on wSD next cycle
        ld_d = {ld_q[CHAIN_LEN-2:0], 1'b0};
        if (cnt_q == LEN_LAST) begin
          cnt_d   = '0;
          state_d = nocapt_q ? ST_UNLOAD : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (cnt_q == CAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        sh_d = {sh_q[CHAIN_LEN-2:0], rQ8};
        if (cnt_q == LEN_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered, so they are derived from the upcoming state.
  always_comb begin
    se_d    = (state_d == ST_LOAD) || (state_d == ST_UNLOAD);
    sd_d    = (state_d == ST_LOAD) ? ld_d[CHAIN_LEN-1] : 1'b0;
    d_d     = (state_d == ST_CAPTURE) ? dfunc_d : 1'b0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    resp_d  = resp_q;
    match_d = match_q;
    if (start_acc) begin
      resp_d  = '0;
      match_d = 1'b0;
    end else if (state_d == ST_DONE) begin
      resp_d  = sh_d;
      match_d = (sh_d == exp_q);
    end
  end

  assign wSE    = se_q;
  assign wSD    = sd_q;
  assign wD     = d_q;
  assign wBusy  = busy_q;
  assign wDone  = done_q;
  assign wMatch = match_q;
  assign wResp  = resp_q;

`ifdef SCAN_MISR_EN
  logic [7:0] misr_data;

  if (CHAIN_LEN >= 8) begin : g_trunc
    assign misr_data = resp_q[7:0];
  end else begin : g_zext
    assign misr_data = {{(8 - CHAIN_LEN){1'b0}}, resp_q};
  end

  scan_misr u_misr (
    .clk_i  (rclk),
    .rst_i  (rreset),
    .en_i   (state_q == ST_DONE),
    .data_i (misr_data),
    .sig_o  (wSig)
  );
`endif

endmodule

// File: doc/scan_ctrl8.md
# scan_ctrl8

Scan test controller for the 8-stage scan flop chain `FF_scan8`. It sits directly upstream of the chain and drives its scan enable, scan data and functional data inputs. It also consumes the chain's serial output `Q8`. Each run shifts a stimulus pattern in, pulses functional capture, shifts the response out, and compares it against an expected vector.

## Interface
Parameters:
- `CHAIN_LEN`, 8, number of scan stages; legal range 2..32.
- `CAPT_CYCLES`, 1, functional capture cycles per run; legal range 1..4.

Ports:
- `rclk` in 1: single clock; all state updates on the rising edge.
- `rreset` in 1: reset, synchronous and active-high.
- `rStart` in 1: run request; sampled only in IDLE.
- `rNoCapt` in 1: when high at start, the capture phase is skipped (shift-integrity run).
- `rPattern` in CHAIN_LEN: stimulus vector, latched at start.
- `rExpect` in CHAIN_LEN: expected response, latched at start.
- `rDfunc` in 1: functional data value driven onto the chain during capture, latched at start.
- `rQ8` in 1: serial output of the last chain stage.
- `wSE` out 1: scan enable to the chain.
- `wSD` out 1: scan data to the chain.
- `wD` out 1: functional data to the chain.
- `wResp` out CHAIN_LEN: unloaded response; holds its value until the next start.
- `wBusy` out 1: high from the cycle after start through the DONE cycle.
- `wDone` out 1: one-cycle pulse at the end of a run.
- `wMatch` out 1: `wResp == rExpect` (latched value); valid with `wDone` and held until the next start.

## Operation
- FSM states: IDLE → LOAD → CAPTURE → UNLOAD → DONE → IDLE. When `rNoCapt` is set, LOAD goes directly to UNLOAD.
- **IDLE**
  - `wSE=0`, `wSD=0`, `wD=0`.
  - `rStart=1` latches `rPattern`, `rExpect`, `rDfunc` and `rNoCapt`, clears the bit counter, and moves to LOAD.
- **LOAD** (CHAIN_LEN cycles)
  - `wSE=1`.
  - In shift cycle k (0-based), `wSD = pattern[CHAIN_LEN-1-k]`.
  - After the last shift, stage j (1 = nearest SD) holds `pattern[j-1]`.
- **CAPTURE** (CAPT_CYCLES cycles)
  - `wSE=0`, `wD = latched rDfunc`, `wSD=0`.
- **UNLOAD** (CHAIN_LEN cycles)
  - `wSE=1`, `wSD=0`.
  - In cycle k, `rQ8` is sampled into `resp[CHAIN_LEN-1-k]`.
- **DONE** (1 cycle)
  - `wDone=1`; `wMatch` and `wResp` are updated.
  - All chain drives return to 0.
  - `rStart` in this cycle is ignored.
- The bit counter is `$clog2(CHAIN_LEN)+1` bits wide and resets to 0 on each phase entry. The phase ends when the counter reaches the phase length minus 1.

## Timing
- All outputs are registered.
- Reset values: every output is 0, the state is IDLE, and the latches and counter are 0.
- Start sampled at edge 0:
  - LOAD occupies cycles 1..N.
  - CAPTURE occupies cycles N+1..N+C.
  - UNLOAD occupies the next N cycles.
  - DONE is at cycle 2N+C+1, which is 18 for the defaults.
  - With `rNoCapt`, DONE is at cycle 2N+1.
- `rStart` while busy is ignored; there is no queueing.
- `rreset` asserted mid-run:
  - The next edge forces IDLE and all outputs to 0.
  - `wDone` does not pulse.
  - Chain contents are left as they are.
- `rreset` and `rStart` high together: reset wins.
- Input changes after the start edge have no effect on the run in progress.

## Configuration
- `SCAN_MISR_EN` defined:
  - Adds output `wSig` [7:0], an 8-bit MISR (polynomial x^8+x^4+x^3+x^2+1).
  - The MISR folds each completed `wResp` (zero-extended or truncated to 8 bits) in the DONE cycle.
  - It is cleared only by `rreset`.
- `SCAN_MISR_EN` undefined: no `wSig` port and no MISR logic.

## Structure
- The shared package `scan_pkg` holds:
  - the state encoding (IDLE=0, LOAD=1, CAPTURE=2, UNLOAD=3, DONE=4);
  - the MISR polynomial constant `SCAN_MISR_POLY = 8'h1D`.
- Sub-module `scan_misr` is instantiated only under `SCAN_MISR_EN`.
- The FSM, counter and shift/sample registers stay in `scan_ctrl8`.

## Test plan
The bench uses the `FF_scan8` chain, in which all stages capture the shared `rD` when SE=0.
- **Reset values:** reset for 3 cycles → all outputs 0, `wBusy=0`.
- **Shift integrity:** `rPattern=8'hA5`, `rNoCapt=1`, `rExpect=8'hA5` → `wDone` at cycle 17, `wResp=8'hA5`, `wMatch=1`.
- **Capture of ones:** `rPattern=8'h3C`, `rDfunc=1`, `rExpect=8'hFF` → `wDone` at cycle 18, `wResp=8'hFF`, `wMatch=1`.
- **Mismatch:** `rPattern=8'hFF`, `rDfunc=0`, `rExpect=8'hFF` → `wResp=8'h00`, `wMatch=0`.
- **Busy and reset interaction:**
  - A second `rStart` at cycle 5 is ignored.
  - `rreset` at cycle 10 → IDLE next cycle, `wSE=0`, no `wDone`.
  - A new start afterwards completes normally.
- **MISR (with `SCAN_MISR_EN`):** two shift-integrity runs with 8'h01 then 8'h02 → `wSig` equals the bench reference MISR model after each `wDone`.
